// File: rtl/buffer_est_pkg.sv
// Shared types and constants for the buffer-estimation traffic source.
// Holds the FSM state enum, the default counter width and the LFSR taps.
package buffer_est_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    GAP,
    DONE
  } state_e;

  localparam int CNT_W_DEF = 32;

  // Maximal-length Fibonacci taps, bit i set = state bit i feeds back
  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

  // Unlisted widths fall back to the two top bits; not maximal length
  function automatic logic [31:0] lfsr_taps(input int w);
    logic [31:0] t;
    if (w == 8) begin
      t = 32'(LFSR_TAPS_8);
    end else if (w == 16) begin
      t = 32'(LFSR_TAPS_16);
    end else if (w == 32) begin
      t = LFSR_TAPS_32;
    end else begin
      t = 32'(2'b11) << (w - 2);
    end
    return t;
  endfunction

endpackage

// File: rtl/burst_write_gen_sat_counter.sv
// Saturating statistics counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter
  import buffer_est_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic sat;

  assign sat = &cnt_o;

  // Clear wins over increment; increment stops at all-ones
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && !sat) begin
      cnt_o <= cnt_o + W'(1);
    end
  end

endmodule

// File: rtl/burst_write_gen.sv
// Burst write traffic source for the FIFO write side, with statistics.
// Define BURST_GEN_PRBS_EN to emit LFSR data instead of a count.
module burst_write_gen
  import buffer_est_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int BURST_LEN  = 16,
  parameter int GAP_CYCLES = 4,
  parameter int NUM_BURSTS = 8,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              fifo_full_i,
  output logic              we_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  word_cnt_o,
  output logic [CNT_W-1:0]  burst_cnt_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int BW =
    (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int GW =
    (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [BW-1:0] BEAT_LAST =
    BW'(BURST_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] BURST_LAST =
    CNT_W'((NUM_BURSTS > 0) ? NUM_BURSTS - 1 : 0);
  localparam logic [CNT_W-1:0] BURST_ALL =
    CNT_W'(NUM_BURSTS);

`ifdef BURST_GEN_PRBS_EN
  localparam logic [DATA_W-1:0] TAPS =
    DATA_W'(lfsr_taps(DATA_W));
  localparam logic [DATA_W-1:0] SEED = '1;
`else
  localparam logic [DATA_W-1:0] SEED = '0;
`endif

  state_e state_q;
  state_e state_d;

  logic [BW-1:0]     beat_q;
  logic [GW-1:0]     gap_q;
  logic              stop_pend_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_nxt;

  logic go;
  logic accept;
  logic stall;
  logic last_beat;
  logic stop_seen;
  logic last_burst;
  logic bursts_done;

  assign we_o    = (state_q == BURST) & ~fifo_full_i;
  assign wdata_o = data_q;
  assign busy_o  = (state_q == BURST) | (state_q == GAP);
  assign done_o  = (state_q == DONE);

  // Next data word: LFSR step or increment, only used on accept
`ifdef BURST_GEN_PRBS_EN
  always_comb begin
    data_nxt = {data_q[DATA_W-2:0], ^(data_q & TAPS)};
  end
`else
  always_comb begin
    data_nxt = data_q + DATA_W'(1);
  end
`endif

  // Next-state logic and per-cycle event decode
  always_comb begin
    state_d     = state_q;
    go          = 1'b0;
    accept      = we_o;
    stall       = (state_q == BURST) & fifo_full_i;
    last_beat   = we_o & (beat_q == BEAT_LAST);
    stop_seen   = stop_pend_q | stop_i;
    last_burst  = (NUM_BURSTS != 0) &&
                  (burst_cnt_o == BURST_LAST);
    bursts_done = (NUM_BURSTS != 0) &&
                  (burst_cnt_o >= BURST_ALL);
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = BURST;
          go      = 1'b1;
        end
      end
      BURST: begin
        if (last_beat) begin
          if (last_burst || stop_seen) begin
            state_d = DONE;
          end else if (GAP_CYCLES == 0) begin
            state_d = BURST;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (stop_seen || bursts_done) begin
          state_d = DONE;
        end else if (gap_q == GAP_LAST) begin
          state_d = BURST;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, beat/gap position, stop flag and data register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      gap_q       <= '0;
      stop_pend_q <= 1'b0;
      data_q      <= SEED;
    end else begin
      state_q <= state_d;
      if (go) begin
        beat_q      <= '0;
        gap_q       <= '0;
        stop_pend_q <= stop_i;
        data_q      <= SEED;
      end else begin
        if (stop_i && busy_o) begin
          stop_pend_q <= 1'b1;
        end
        if (accept) begin
          data_q <= data_nxt;
          beat_q <= last_beat ? '0
                              : beat_q + BW'(1);
        end
        if (state_q == GAP && state_d == GAP) begin
          gap_q <= gap_q + GW'(1);
        end else begin
          gap_q <= '0;
        end
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_word_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (go),
    .inc_i  (accept),
    .cnt_o  (word_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_burst_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (go),
    .inc_i  (last_beat),
    .cnt_o  (burst_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (go),
    .inc_i  (stall),
    .cnt_o  (stall_cnt_o)
  );

endmodule

// File: tb/tb_burst_write_gen.sv
// Directed bench for burst_write_gen over three parameter sets.
// Data expectations follow BURST_GEN_PRBS_EN when defined.
module tb_burst_write_gen;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // A: BURST_LEN=4 GAP=2 NUM_BURSTS=3
  logic a_start, a_stop, a_full;
  logic a_we, a_busy, a_done;
  logic [7:0]  a_wdata;
  logic [15:0] a_wc, a_bc, a_sc;

  // B: BURST_LEN=3 GAP=0 NUM_BURSTS=2
  logic b_start, b_stop, b_full;
  logic b_we, b_busy, b_done;
  logic [7:0]  b_wdata;
  logic [15:0] b_wc, b_bc, b_sc;

  // C: BURST_LEN=4 GAP=2 NUM_BURSTS=0
  logic c_start, c_stop, c_full;
  logic c_we, c_busy, c_done;
  logic [7:0]  c_wdata;
  logic [15:0] c_wc, c_bc, c_sc;

  burst_write_gen #(
    .DATA_W(8), .BURST_LEN(4), .GAP_CYCLES(2),
    .NUM_BURSTS(3), .CNT_W(16)
  ) u_a (
    .clk_i(clk), .rst_ni(rst_n),
    .start_i(a_start), .stop_i(a_stop),
    .fifo_full_i(a_full), .we_o(a_we),
    .wdata_o(a_wdata), .busy_o(a_busy),
    .done_o(a_done), .word_cnt_o(a_wc),
    .burst_cnt_o(a_bc), .stall_cnt_o(a_sc)
  );

  burst_write_gen #(
    .DATA_W(8), .BURST_LEN(3), .GAP_CYCLES(0),
    .NUM_BURSTS(2), .CNT_W(16)
  ) u_b (
    .clk_i(clk), .rst_ni(rst_n),
    .start_i(b_start), .stop_i(b_stop),
    .fifo_full_i(b_full), .we_o(b_we),
    .wdata_o(b_wdata), .busy_o(b_busy),
    .done_o(b_done), .word_cnt_o(b_wc),
    .burst_cnt_o(b_bc), .stall_cnt_o(b_sc)
  );

  burst_write_gen #(
    .DATA_W(8), .BURST_LEN(4), .GAP_CYCLES(2),
    .NUM_BURSTS(0), .CNT_W(16)
  ) u_c (
    .clk_i(clk), .rst_ni(rst_n),
    .start_i(c_start), .stop_i(c_stop),
    .fifo_full_i(c_full), .we_o(c_we),
    .wdata_o(c_wdata), .busy_o(c_busy),
    .done_o(c_done), .word_cnt_o(c_wc),
    .burst_cnt_o(c_bc), .stall_cnt_o(c_sc)
  );

  // n-th word of a run
  function automatic logic [7:0] exp_data(input int n);
    logic [7:0] s;
`ifdef BURST_GEN_PRBS_EN
    s = 8'hFF;
    for (int i = 0; i < n; i++) begin
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    end
`else
    s = 8'(n);
`endif
    return s;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    a_start = 0; a_stop = 0; a_full = 0;
    b_start = 0; b_stop = 0; b_full = 0;
    c_start = 0; c_stop = 0; c_full = 0;
    #12;
    checks++;
    if ({a_we, a_busy, a_done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 000",
               {a_we, a_busy, a_done});
    end
    checks++;
    if (a_wdata !== exp_data(0)) begin
      errors++;
      $display("FAIL reset_wdata got %0h exp %0h",
               a_wdata, exp_data(0));
    end
    checks++;
    if ({a_wc, a_bc, a_sc} !== 48'd0) begin
      errors++;
      $display("FAIL reset_cnts got %0h %0h %0h exp 0",
               a_wc, a_bc, a_sc);
    end
    checks++;
    if ({b_done, c_done, b_busy, c_busy} !== 4'b0) begin
      errors++;
      $display("FAIL reset_bc got %b exp 0000",
               {b_done, c_done, b_busy, c_busy});
    end
    #5;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_free_run;
    logic [15:0] pat;
    int n;
    pat = 16'b1111_0011_1100_1111;
    n = 0;
    a_start = 1; tick; a_start = 0;
    for (int k = 0; k < 16; k++) begin
      a_start = (k == 5);
      #1;
      checks++;
      if (a_we !== pat[15-k] || a_busy !== 1'b1) begin
        errors++;
        $display("FAIL free_we k%0d got %b/%b exp %b/1",
                 k, a_we, a_busy, pat[15-k]);
      end
      if (pat[15-k]) begin
        checks++;
        if (a_wdata !== exp_data(n)) begin
          errors++;
          $display("FAIL free_data n%0d got %0h exp %0h",
                   n, a_wdata, exp_data(n));
        end
        n++;
      end
      tick;
    end
    a_start = 0;
    checks++;
    if ({a_done, a_busy, a_we} !== 3'b100) begin
      errors++;
      $display("FAIL free_done got %b exp 100",
               {a_done, a_busy, a_we});
    end
    checks++;
    if (a_wc !== 16'd12 || a_bc !== 16'd3 ||
        a_sc !== 16'd0) begin
      errors++;
      $display("FAIL free_cnts got %0d %0d %0d exp 12 3 0",
               a_wc, a_bc, a_sc);
    end
  endtask

  task automatic test_backpressure;
    logic [20:0] pat;
    int n;
    pat = 21'b11_00000_11_00_1111_00_1111;
    n = 0;
    a_start = 1; tick; a_start = 0;
    for (int k = 0; k < 21; k++) begin
      a_full = (k >= 2 && k <= 6);
      #1;
      checks++;
      if (a_we !== pat[20-k] || a_done !== 1'b0) begin
        errors++;
        $display("FAIL bp_we k%0d got %b/%b exp %b/0",
                 k, a_we, a_done, pat[20-k]);
      end
      checks++;
      if (a_wdata !== exp_data(n)) begin
        errors++;
        $display("FAIL bp_data k%0d got %0h exp %0h",
                 k, a_wdata, exp_data(n));
      end
      if (pat[20-k]) n++;
      tick;
    end
    a_full = 0;
    checks++;
    if (a_done !== 1'b1) begin
      errors++;
      $display("FAIL bp_done got %b exp 1", a_done);
    end
    checks++;
    if (a_wc !== 16'd12 || a_bc !== 16'd3 ||
        a_sc !== 16'd5) begin
      errors++;
      $display("FAIL bp_cnts got %0d %0d %0d exp 12 3 5",
               a_wc, a_bc, a_sc);
    end
  endtask

`ifdef BURST_GEN_PRBS_EN
  task automatic test_prbs;
    int n;
    int k;
    n = 0;
    k = 0;
    a_start = 1; tick; a_start = 0;
    while (n < 10 && k < 40) begin
      a_full = (k == 3 || k == 4 || k == 7);
      #1;
      checks++;
      if (a_wdata !== exp_data(n)) begin
        errors++;
        $display("FAIL prbs_data k%0d got %0h exp %0h",
                 k, a_wdata, exp_data(n));
      end
      if (a_we) n++;
      tick;
      k++;
    end
    a_full = 0;
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL prbs_count got %0d exp 10", n);
    end
    k = 0;
    while (!a_done && k < 20) begin
      tick;
      k++;
    end
    checks++;
    if (a_done !== 1'b1 || a_sc !== 16'd3) begin
      errors++;
      $display("FAIL prbs_end got %b/%0d exp 1/3",
               a_done, a_sc);
    end
  endtask
`endif

  task automatic test_zero_gap;
    b_start = 1; tick; b_start = 0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (b_we !== 1'b1 || b_wdata !== exp_data(k)) begin
        errors++;
        $display("FAIL zg_beat k%0d got %b/%0h exp 1/%0h",
                 k, b_we, b_wdata, exp_data(k));
      end
      tick;
    end
    checks++;
    if ({b_done, b_we} !== 2'b10 || b_bc !== 16'd2 ||
        b_wc !== 16'd6) begin
      errors++;
      $display("FAIL zg_end got %b %0d %0d exp 10 2 6",
               {b_done, b_we}, b_bc, b_wc);
    end
  endtask

  task automatic test_stop_burst;
    logic [9:0] pat;
    pat = 10'b1111_00_1111;
    c_start = 1; tick; c_start = 0;
    for (int k = 0; k < 10; k++) begin
      c_stop = (k == 7);
      checks++;
      if (c_we !== pat[9-k]) begin
        errors++;
        $display("FAIL stop_we k%0d got %b exp %b",
                 k, c_we, pat[9-k]);
      end
      tick;
    end
    c_stop = 0;
    tick;
    tick;
    checks++;
    if ({c_done, c_we} !== 2'b10 || c_wc !== 16'd8 ||
        c_bc !== 16'd2) begin
      errors++;
      $display("FAIL stop_end got %b %0d %0d exp 10 8 2",
               {c_done, c_we}, c_wc, c_bc);
    end
  endtask

  task automatic test_stop_gap;
    c_start = 1; tick; c_start = 0;
    tick; tick; tick; tick;
    checks++;
    if ({c_we, c_busy} !== 2'b01) begin
      errors++;
      $display("FAIL sgap_in got %b exp 01",
               {c_we, c_busy});
    end
    c_stop = 1; tick; c_stop = 0;
    checks++;
    if ({c_done, c_busy, c_we} !== 3'b100 ||
        c_wc !== 16'd4 || c_bc !== 16'd1) begin
      errors++;
      $display("FAIL sgap_end got %b %0d %0d exp 100 4 1",
               {c_done, c_busy, c_we}, c_wc, c_bc);
    end
  endtask

  task automatic test_start_stop;
    c_start = 1; c_stop = 1; tick;
    c_start = 0; c_stop = 0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (c_we !== 1'b1 || c_wdata !== exp_data(k)) begin
        errors++;
        $display("FAIL ss_beat k%0d got %b/%0h exp 1/%0h",
                 k, c_we, c_wdata, exp_data(k));
      end
      tick;
    end
    checks++;
    if (c_done !== 1'b1 || c_wc !== 16'd4 ||
        c_bc !== 16'd1) begin
      errors++;
      $display("FAIL ss_end got %b %0d %0d exp 1 4 1",
               c_done, c_wc, c_bc);
    end
  endtask

  task automatic test_reset_mid;
    a_start = 1; tick; a_start = 0;
    tick; tick;
    checks++;
    if (a_we !== 1'b1 || a_wdata !== exp_data(2)) begin
      errors++;
      $display("FAIL rm_pre got %b/%0h exp 1/%0h",
               a_we, a_wdata, exp_data(2));
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_we, a_busy, a_done} !== 3'b000 ||
        a_wdata !== exp_data(0) || a_wc !== 16'd0) begin
      errors++;
      $display("FAIL rm_async got %b %0h %0d exp 000 %0h 0",
               {a_we, a_busy, a_done}, a_wdata, a_wc,
               exp_data(0));
    end
    #3;
    rst_n = 1'b1;
    tick;
    checks++;
    if ({a_we, a_busy, a_done} !== 3'b000) begin
      errors++;
      $display("FAIL rm_idle got %b exp 000",
               {a_we, a_busy, a_done});
    end
    a_start = 1; tick; a_start = 0;
    checks++;
    if (a_we !== 1'b1 || a_wdata !== exp_data(0) ||
        {a_wc, a_bc, a_sc} !== 48'd0) begin
      errors++;
      $display("FAIL rm_restart got %b %0h %0d %0d %0d",
               a_we, a_wdata, a_wc, a_bc, a_sc);
    end
    tick;
    checks++;
    if (a_wdata !== exp_data(1) || a_wc !== 16'd1) begin
      errors++;
      $display("FAIL rm_next got %0h %0d exp %0h 1",
               a_wdata, a_wc, exp_data(1));
    end
  endtask

  initial begin
    test_reset;
    test_free_run;
    test_backpressure;
`ifdef BURST_GEN_PRBS_EN
    test_prbs;
`endif
    test_zero_gap;
    test_stop_burst;
    test_stop_gap;
    test_start_stop;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/burst_write_gen.md
Name: burst_write_gen

Overview:
- Upstream traffic source for the buffer-throughput bench; drives the FIFO write side (we, wdata) in a single clock domain.
- Emits NUM_BURSTS bursts of BURST_LEN words separated by GAP_CYCLES idle cycles. Throttles on FIFO full and never overflows the FIFO.
- Counts accepted words and full-stall cycles; the bench uses these counts for throughput and buffer-depth estimation.

Parameters:
- DATA_W, 8: write data width.
- BURST_LEN, 16: words per burst, >=1.
- GAP_CYCLES, 4: idle cycles between bursts, >=0.
- NUM_BURSTS, 8: bursts per run; 0 = run until stop_i.
- CNT_W, 32: width of statistics counters.

Ports:
- clk_i, input, 1: single clock.
- rst_ni, input, 1: asynchronous active-low reset.
- start_i, input, 1: pulse; begins a run from IDLE or DONE.
- stop_i, input, 1: pulse; requests graceful end of run.
- fifo_full_i, input, 1: full flag from the downstream FIFO write side.
- we_o, output, 1: FIFO write enable.
- wdata_o, output, DATA_W: FIFO write data.
- busy_o, output, 1: high in BURST or GAP.
- done_o, output, 1: high in DONE.
- word_cnt_o, output, CNT_W: accepted writes this run.
- burst_cnt_o, output, CNT_W: completed bursts this run.
- stall_cnt_o, output, CNT_W: BURST cycles blocked by full.

Behaviour:
- Reset (async assert, sync release): state=IDLE, wdata_o=0, we_o=0, busy_o=0, done_o=0, all counters=0, beat/gap counters=0.
- FSM states:
  - IDLE/DONE -> BURST on start_i. Start clears word/burst/stall counters and wdata_o.
  - BURST -> GAP when the last beat is accepted and GAP_CYCLES>0.
  - BURST -> BURST (next burst) when the last beat is accepted and GAP_CYCLES=0.
  - BURST -> DONE when the last beat of the final burst is accepted, or when the last beat is accepted with a stop pending.
  - GAP -> BURST after exactly GAP_CYCLES cycles in GAP.
  - GAP -> DONE at the first GAP cycle with a stop pending, or when the final burst is complete.
- "Final burst" means burst_cnt reaches NUM_BURSTS; it is never reached when NUM_BURSTS=0.
- we_o = (state==BURST) & ~fifo_full_i. The combinational path from fifo_full_i is intentional: zero-latency throttle, so no write is ever issued while full.
- A write is accepted on each clock edge where we_o=1. On accept:
  - wdata_o increments, wrapping mod 2^DATA_W.
  - word_cnt increments.
  - The beat counter advances, wrapping at BURST_LEN.
- The first word of a run is 0.
- BURST cycle with fifo_full_i=1: stall_cnt increments; beat counter, data and state hold.
- Statistics counters saturate at all-ones; they do not wrap.
- burst_cnt increments in the same cycle the last beat of a burst is accepted.
- stop_i:
  - Sets a sticky stop-pending flag.
  - In BURST, the current burst completes, then DONE.
  - In GAP, DONE next cycle.
  - In IDLE/DONE, ignored.
- start_i while busy_o=1 is ignored. start_i and stop_i in the same cycle from IDLE: start wins, and stop is latched as pending, so exactly one burst is sent.
- Counters hold their values in DONE until the next start.
- Reset asserted mid-burst: immediate return to IDLE, we_o low asynchronously. No partial-burst state survives.

Optional Feature:
- Macro BURST_GEN_PRBS_EN.
- Defined: wdata_o comes from a DATA_W-bit Fibonacci LFSR (seed all-ones at reset/start) that advances only on accept. Used for data-integrity checks through the async FIFO.
- Undefined: wdata_o is an incrementing counter.
- FSM, handshake and counters are identical in both builds.

Decomposition:
- Shared package buffer_est_pkg:
  - State enum (IDLE, BURST, GAP, DONE).
  - Default CNT_W.
  - LFSR tap constants per DATA_W (8/16/32).
- One natural sub-module: sat_counter, a CNT_W-bit saturating counter with clear and increment-enable inputs, instantiated three times.
- LFSR and FSM stay inline.

Test Plan:
- Free-running FIFO: BURST_LEN=4, GAP=2, NUM_BURSTS=3, fifo_full_i=0, start pulse.
  - Required: we_o pattern 1111 00 1111 00 1111, then done_o=1.
  - wdata 0..11; word_cnt=12, burst_cnt=3, stall_cnt=0.
- Backpressure: hold fifo_full_i=1 for 5 cycles starting at beat 2 of burst 1.
  - Required: we_o=0 during those 5 cycles; no data skipped or repeated; stall_cnt=5.
  - Completion is delayed by exactly 5 cycles.
- Zero gap: GAP=0, BURST_LEN=3, NUM_BURSTS=2.
  - Required: 6 consecutive we_o cycles, then DONE; burst_cnt=2.
- Stop: NUM_BURSTS=0, stop_i at beat 1 of burst 2 (BURST_LEN=4).
  - Required: burst 2 finishes, then DONE; word_cnt=8.
  - Separately, stop_i during GAP: DONE next cycle, we_o stays 0.
- Reset mid-burst: drop rst_ni at beat 2.
  - Required: we_o=0 immediately and state IDLE.
  - A new start gives wdata_o=0 and all counters=0.
- PRBS build (BURST_GEN_PRBS_EN): DATA_W=8, 10 writes.
  - Required: data sequence matches the reference LFSR model from seed 0xFF.
  - The sequence does not advance during stall cycles.
